// File: rtl/decode_queue.sv
// decode_queue: MIPS32 decoder feeding a small FIFO of decoded bundles.
// Define DECODE_TRAP_EN to decode break/syscall/teq as trapping ops.
module decode_queue #(
  parameter int DEPTH = 4,
  parameter int PC_W  = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [31:0]            in_instr,
  input  logic [PC_W-1:0]        in_pc,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [PC_W-1:0]        out_pc,
  output logic [5:0]             out_op,
  output logic [4:0]             out_rs,
  output logic [4:0]             out_rt,
  output logic [4:0]             out_rd,
  output logic [4:0]             out_shamt,
  output logic [15:0]            out_imm,
  output logic [25:0]            out_addr,
  output logic                   out_wr,
  output logic                   out_exc,
  output logic [4:0]             out_cause,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    RD_NONE, RD_RT, RD_RD, RD_31
  } rd_sel_e;

  typedef struct packed {
    logic [5:0] op;
    logic [4:0] fld;
    rd_sel_e    rd_sel;
    logic       wr;
  } ctl_t;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [5:0]      op;
    logic [4:0]      rs;
    logic [4:0]      rt;
    logic [4:0]      rd;
    logic [4:0]      sh;
    logic [15:0]     imm;
    logic [25:0]     addr;
    logic            wr;
    logic            exc;
    logic [4:0]      cause;
  } ent_t;

  // Field-use masks: {rs, rt, shamt, imm, addr}
  localparam logic [4:0] U_NO  = 5'b00000;
  localparam logic [4:0] U_RS  = 5'b10000;
  localparam logic [4:0] U_RT  = 5'b01000;
  localparam logic [4:0] U_RR  = 5'b11000;
  localparam logic [4:0] U_SH  = 5'b01100;
  localparam logic [4:0] U_I   = 5'b11010;
  localparam logic [4:0] U_LUI = 5'b01010;
  localparam logic [4:0] U_BZ  = 5'b10010;
  localparam logic [4:0] U_J   = 5'b00001;

  function automatic ctl_t mk(
    input logic [5:0] op,
    input logic [4:0] fld,
    input rd_sel_e    sel,
    input logic       wr
  );
    ctl_t c;
    c.op     = op;
    c.fld    = fld;
    c.rd_sel = sel;
    c.wr     = wr;
    return c;
  endfunction

  logic [5:0] w_opc;
  logic [5:0] w_fn;
  logic [4:0] w_rsf;
  logic [4:0] w_rtf;
  ctl_t       w_ctl;
  logic       w_exc;
  logic [4:0] w_cause;
  ent_t       w_ent;
  ent_t       w_head;
  logic       w_push;
  logic       w_pop;

  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [CW-1:0] r_count;
  ent_t          r_hold;
  ent_t          r_mem [DEPTH];

  assign w_opc = in_instr[31:26];
  assign w_fn  = in_instr[5:0];
  assign w_rsf = in_instr[25:21];
  assign w_rtf = in_instr[20:16];

  always_comb begin
    w_ctl = '0;
    unique case (w_opc)
      6'h00: begin
        unique case (w_fn)
          6'h00: if (w_rsf == '0) w_ctl = mk(6'd11, U_SH, RD_RD, 1'b1);
          6'h02: if (w_rsf == '0) w_ctl = mk(6'd12, U_SH, RD_RD, 1'b1);
          6'h03: if (w_rsf == '0) w_ctl = mk(6'd13, U_SH, RD_RD, 1'b1);
          6'h04: w_ctl = mk(6'd14, U_RR, RD_RD, 1'b1);
          6'h06: w_ctl = mk(6'd15, U_RR, RD_RD, 1'b1);
          6'h07: w_ctl = mk(6'd16, U_RR, RD_RD, 1'b1);
          6'h08: w_ctl = mk(6'd17, U_RS, RD_NONE, 1'b0);
          6'h09: w_ctl = mk(6'd33, U_RS, RD_RD, 1'b1);
`ifdef DECODE_TRAP_EN
          6'h0C: w_ctl = mk(6'd46, U_NO, RD_NONE, 1'b0);
          6'h0D: w_ctl = mk(6'd45, U_NO, RD_NONE, 1'b0);
          6'h34: w_ctl = mk(6'd47, U_RR, RD_NONE, 1'b0);
`endif
          6'h10: w_ctl = mk(6'd36, U_NO, RD_RD, 1'b1);
          6'h11: w_ctl = mk(6'd34, U_RS, RD_NONE, 1'b0);
          6'h12: w_ctl = mk(6'd37, U_NO, RD_RD, 1'b1);
          6'h13: w_ctl = mk(6'd35, U_RS, RD_NONE, 1'b0);
          6'h19: w_ctl = mk(6'd51, U_RR, RD_NONE, 1'b0);
          6'h1A: w_ctl = mk(6'd52, U_RR, RD_NONE, 1'b0);
          6'h1B: w_ctl = mk(6'd53, U_RR, RD_NONE, 1'b0);
          6'h20: w_ctl = mk(6'd1,  U_RR, RD_RD, 1'b1);
          6'h21: w_ctl = mk(6'd2,  U_RR, RD_RD, 1'b1);
          6'h22: w_ctl = mk(6'd3,  U_RR, RD_RD, 1'b1);
          6'h23: w_ctl = mk(6'd4,  U_RR, RD_RD, 1'b1);
          6'h24: w_ctl = mk(6'd5,  U_RR, RD_RD, 1'b1);
          6'h25: w_ctl = mk(6'd6,  U_RR, RD_RD, 1'b1);
          6'h26: w_ctl = mk(6'd7,  U_RR, RD_RD, 1'b1);
          6'h27: w_ctl = mk(6'd8,  U_RR, RD_RD, 1'b1);
          6'h2A: w_ctl = mk(6'd9,  U_RR, RD_RD, 1'b1);
          6'h2B: w_ctl = mk(6'd10, U_RR, RD_RD, 1'b1);
          default: ;
        endcase
      end
      6'h01: if (w_rtf == 5'd1) w_ctl = mk(6'd54, U_BZ, RD_NONE, 1'b0);
      6'h02: w_ctl = mk(6'd30, U_J,   RD_NONE, 1'b0);
      6'h03: w_ctl = mk(6'd31, U_J,   RD_31,   1'b1);
      6'h04: w_ctl = mk(6'd25, U_I,   RD_NONE, 1'b0);
      6'h05: w_ctl = mk(6'd26, U_I,   RD_NONE, 1'b0);
      6'h08: w_ctl = mk(6'd18, U_I,   RD_RT,   1'b1);
      6'h09: w_ctl = mk(6'd19, U_I,   RD_RT,   1'b1);
      6'h0A: w_ctl = mk(6'd27, U_I,   RD_RT,   1'b1);
      6'h0B: w_ctl = mk(6'd28, U_I,   RD_RT,   1'b1);
      6'h0C: w_ctl = mk(6'd20, U_I,   RD_RT,   1'b1);
      6'h0D: w_ctl = mk(6'd21, U_I,   RD_RT,   1'b1);
      6'h0E: w_ctl = mk(6'd22, U_I,   RD_RT,   1'b1);
      6'h0F: w_ctl = mk(6'd29, U_LUI, RD_RT,   1'b1);
      6'h10: begin
        if (in_instr[25] && in_instr[24:6] == '0 && w_fn == 6'h18)
          w_ctl = mk(6'd44, U_NO, RD_NONE, 1'b0);
        else if (w_rsf == 5'd0)
          w_ctl = mk(6'd48, U_RT, RD_RT, 1'b1);
        else if (w_rsf == 5'd4)
          w_ctl = mk(6'd49, U_RT, RD_RD, 1'b0);
      end
      6'h1C: begin
        if (w_fn == 6'h20)
          w_ctl = mk(6'd32, U_RS, RD_RD, 1'b1);
        else if (w_fn == 6'h02)
          w_ctl = mk(6'd50, U_RR, RD_RD, 1'b1);
      end
      6'h20: w_ctl = mk(6'd40, U_I, RD_RT,   1'b1);
      6'h21: w_ctl = mk(6'd41, U_I, RD_RT,   1'b1);
      6'h23: w_ctl = mk(6'd23, U_I, RD_RT,   1'b1);
      6'h24: w_ctl = mk(6'd42, U_I, RD_RT,   1'b1);
      6'h25: w_ctl = mk(6'd43, U_I, RD_RT,   1'b1);
      6'h28: w_ctl = mk(6'd38, U_I, RD_NONE, 1'b0);
      6'h29: w_ctl = mk(6'd39, U_I, RD_NONE, 1'b0);
      6'h2B: w_ctl = mk(6'd24, U_I, RD_NONE, 1'b0);
      default: ;
    endcase
  end

  // teq traps unconditionally here; execute qualifies it with rs==rt
  always_comb begin
    w_exc   = 1'b0;
    w_cause = 5'd0;
    unique case (w_ctl.op)
      6'd0: begin
        w_exc   = 1'b1;
        w_cause = 5'd10;
      end
`ifdef DECODE_TRAP_EN
      6'd45: begin
        w_exc   = 1'b1;
        w_cause = 5'd9;
      end
      6'd46: begin
        w_exc   = 1'b1;
        w_cause = 5'd8;
      end
      6'd47: begin
        w_exc   = 1'b1;
        w_cause = 5'd13;
      end
`endif
      default: ;
    endcase
  end

  always_comb begin
    w_ent       = '0;
    w_ent.pc    = in_pc;
    w_ent.op    = w_ctl.op;
    w_ent.wr    = w_ctl.wr;
    w_ent.exc   = w_exc;
    w_ent.cause = w_cause;
    if (w_ctl.fld[4]) w_ent.rs   = in_instr[25:21];
    if (w_ctl.fld[3]) w_ent.rt   = in_instr[20:16];
    if (w_ctl.fld[2]) w_ent.sh   = in_instr[10:6];
    if (w_ctl.fld[1]) w_ent.imm  = in_instr[15:0];
    if (w_ctl.fld[0]) w_ent.addr = in_instr[25:0];
    case (w_ctl.rd_sel)
      RD_RT:   w_ent.rd = in_instr[20:16];
      RD_RD:   w_ent.rd = in_instr[15:11];
      RD_31:   w_ent.rd = 5'd31;
      default: w_ent.rd = 5'd0;
    endcase
  end

  assign in_ready  = r_count < CW'(DEPTH);
  assign out_valid = r_count != '0;
  assign w_push    = in_valid && in_ready && !flush;
  assign w_pop     = out_valid && out_ready && !flush;
  assign count     = r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
      r_hold  <= '0;
    end else if (flush) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + AW'(1);
      if (w_pop) begin
        r_rp   <= r_rp + AW'(1);
        r_hold <= r_mem[r_rp];
      end
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= w_ent;
  end

  // When empty, present the last popped bundle (zero after reset)
  assign w_head = out_valid ? r_mem[r_rp] : r_hold;

  assign out_pc    = w_head.pc;
  assign out_op    = w_head.op;
  assign out_rs    = w_head.rs;
  assign out_rt    = w_head.rt;
  assign out_rd    = w_head.rd;
  assign out_shamt = w_head.sh;
  assign out_imm   = w_head.imm;
  assign out_addr  = w_head.addr;
  assign out_wr    = w_head.wr;
  assign out_exc   = w_head.exc;
  assign out_cause = w_head.cause;

endmodule

// File: tb/tb_decode_queue.sv
// tb_decode_queue: directed checks of decode_queue decode and FIFO behaviour.
// Expectations follow DECODE_TRAP_EN when it is defined for the build.
module tb_decode_queue;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [5:0]  out_op;
  logic [4:0]  out_rs;
  logic [4:0]  out_rt;
  logic [4:0]  out_rd;
  logic [4:0]  out_shamt;
  logic [15:0] out_imm;
  logic [25:0] out_addr;
  logic        out_wr;
  logic        out_exc;
  logic [4:0]  out_cause;
  logic [2:0]  count;

  int n_vec = 0;
  int n_err = 0;

  localparam logic [31:0] ADDU = 32'h0022_1821;

  decode_queue #(.DEPTH(4), .PC_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_op(out_op),
    .out_rs(out_rs), .out_rt(out_rt),
    .out_rd(out_rd), .out_shamt(out_shamt),
    .out_imm(out_imm), .out_addr(out_addr),
    .out_wr(out_wr), .out_exc(out_exc),
    .out_cause(out_cause), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] ins, input logic [31:0] pc);
    in_valid = 1'b1;
    in_instr = ins;
    in_pc    = pc;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic pop1();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_instr = '0;
    in_pc = '0; flush = 1'b0; out_ready = 1'b0;
    #3;
    chk("rst_ready", in_ready, 1);
    chk("rst_valid", out_valid, 0);
    chk("rst_count", count, 0);
    chk("rst_op", out_op, 0);
    chk("rst_pc", out_pc, 0);
    #9 rst_n = 1'b1;

    // addu $3,$1,$2
    push(ADDU, 32'h400);
    chk("addu_valid", out_valid, 1);
    chk("addu_op", out_op, 2);
    chk("addu_rs", out_rs, 1);
    chk("addu_rt", out_rt, 2);
    chk("addu_rd", out_rd, 3);
    chk("addu_wr", out_wr, 1);
    chk("addu_imm", out_imm, 0);
    chk("addu_exc", out_exc, 0);
    chk("addu_pc", out_pc, 32'h400);
    chk("addu_cnt", count, 1);
    pop1();
    chk("pop_valid", out_valid, 0);
    chk("hold_op", out_op, 2);
    chk("hold_rd", out_rd, 3);

    // jal 0x10
    push(32'h0C00_0010, 32'h404);
    chk("jal_op", out_op, 31);
    chk("jal_rd", out_rd, 31);
    chk("jal_wr", out_wr, 1);
    chk("jal_addr", out_addr, 26'h10);
    chk("jal_imm", out_imm, 0);
    chk("jal_rs", out_rs, 0);
    pop1();

    push(32'hFC00_0000, 32'h408);
    chk("ri_op", out_op, 0);
    chk("ri_exc", out_exc, 1);
    chk("ri_cause", out_cause, 10);
    chk("ri_wr", out_wr, 0);
    pop1();

    push(32'h0000_000C, 32'h40C);
    chk("sys_exc", out_exc, 1);
`ifdef DECODE_TRAP_EN
    chk("sys_op", out_op, 46);
    chk("sys_cause", out_cause, 8);
`else
    chk("sys_op", out_op, 0);
    chk("sys_cause", out_cause, 10);
`endif
    pop1();

    // lw $5,8($2)
    push(32'h8C45_0008, 32'h410);
    chk("lw_op", out_op, 23);
    chk("lw_rd", out_rd, 5);
    chk("lw_wr", out_wr, 1);
    chk("lw_imm", out_imm, 8);
    chk("lw_rs", out_rs, 2);
    pop1();

    // sw $5,8($2)
    push(32'hAC45_0008, 32'h414);
    chk("sw_op", out_op, 24);
    chk("sw_rd", out_rd, 0);
    chk("sw_wr", out_wr, 0);
    chk("sw_rt", out_rt, 5);
    pop1();

    // sll $4,$3,2
    push(32'h0003_2080, 32'h418);
    chk("sll_op", out_op, 11);
    chk("sll_rd", out_rd, 4);
    chk("sll_sh", out_shamt, 2);
    chk("sll_rs", out_rs, 0);
    pop1();

    // sll with nonzero rs field is illegal
    push(32'h0023_2080, 32'h41C);
    chk("sllbad_op", out_op, 0);
    chk("sllbad_exc", out_exc, 1);
    chk("sllbad_sh", out_shamt, 0);
    pop1();

    // mtc0 $5,$12
    push(32'h4085_6000, 32'h420);
    chk("mtc0_op", out_op, 49);
    chk("mtc0_rd", out_rd, 12);
    chk("mtc0_wr", out_wr, 0);
    pop1();

    // Fill to full, fifth held upstream
    in_valid = 1'b1;
    in_instr = ADDU;
    for (int i = 0; i < 4; i++) begin
      in_pc = 32'h100 + 4 * i;
      tick();
    end
    in_pc = 32'h110;
    chk("full_cnt", count, 4);
    chk("full_ready", in_ready, 0);
    tick();
    chk("full_hold", count, 4);
    chk("full_head", out_pc, 32'h100);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("pop_cnt", count, 3);
    chk("pop_ready", in_ready, 1);
    chk("pop_head", out_pc, 32'h104);
    tick();
    in_valid = 1'b0;
    chk("fifth_cnt", count, 4);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("order_pc", out_pc, 64'(32'h104 + 4 * i));
      tick();
    end
    out_ready = 1'b0;
    chk("drain_cnt", count, 0);
    chk("drain_valid", out_valid, 0);

    // Flush with same-cycle push and pop
    push(ADDU, 32'h200);
    push(ADDU, 32'h204);
    push(ADDU, 32'h208);
    chk("pre_fl_cnt", count, 3);
    in_valid = 1'b1; in_pc = 32'h2FC;
    flush = 1'b1; out_ready = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    chk("fl_cnt", count, 0);
    chk("fl_valid", out_valid, 0);
    tick();
    chk("fl_idle", count, 0);
    push(ADDU, 32'h300);
    chk("fl_new_pc", out_pc, 32'h300);
    chk("fl_new_cnt", count, 1);

    // Simultaneous push and pop
    in_valid = 1'b1; in_pc = 32'h304; out_ready = 1'b1;
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    chk("pp_cnt", count, 1);
    chk("pp_pc", out_pc, 32'h304);
    pop1();

    // Asynchronous reset with two entries
    push(32'h8C45_0008, 32'h500);
    push(32'h8C45_0008, 32'h504);
    chk("pre_rst_cnt", count, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_cnt", count, 0);
    chk("arst_valid", out_valid, 0);
    chk("arst_ready", in_ready, 1);
    chk("arst_op", out_op, 0);
    chk("arst_pc", out_pc, 0);
    chk("arst_rd", out_rd, 0);
    rst_n = 1'b1;
    push(ADDU, 32'h600);
    chk("post_rst_pc", out_pc, 32'h600);
    chk("post_rst_cnt", count, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/decode_queue.md
DECODE_QUEUE -- requirements
Module: decode_queue

Interface
REQ-001 Parameter DEPTH, default 4, queue entries; power of two, >= 2.
REQ-002 Parameter PC_W, default 32, PC width carried with each instruction.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 in_valid  input  1  fetch offers an instruction.
REQ-006 in_ready  output  1  queue accepts; high when count < DEPTH.
REQ-007 in_instr  input  32  raw MIPS instruction.
REQ-008 in_pc  input  PC_W  instruction address.
REQ-009 flush  input  1  discard all entries and any same-cycle input.
REQ-010 out_valid  output  1  head entry present.
REQ-011 out_ready  input  1  consumer takes head.
REQ-012 out_pc  output  PC_W  PC of head.
REQ-013 out_op  output  6  operation id, 0 = illegal.
REQ-014 out_rs, out_rt, out_rd, out_shamt  output  5 each  register and shift fields.
REQ-015 out_imm  output  16; out_addr  output  26  immediate and jump target.
REQ-016 out_wr  output  1  instruction writes out_rd.
REQ-017 out_exc  output  1; out_cause  output  5  decode-time exception and cause.
REQ-018 count  output  $clog2(DEPTH)+1  occupancy.

Function
REQ-019 Push when in_valid && in_ready && !flush; pop when out_valid && out_ready && !flush; both may occur in one cycle.
REQ-020 Decode is combinational on in_instr; decoded bundle is written into the queue; entry visible on outputs the cycle after push (latency 1).
REQ-021 out_op ids 1..54 in order: add addu sub subu and or xor nor slt sltu sll srl sra sllv srlv srav jr addi addiu andi ori xori lw sw beq bne slti sltiu lui j jal clz jalr mthi mtlo mfhi mflo sb sh lb lh lbu lhu eret break syscall teq mfc0 mtc0 mul multu div divu bgez.
REQ-022 Opcode/funct/rs/rt matching per MIPS32 encodings; sll/srl/sra require instr[25:21]=0; any unmatched encoding gives out_op=0, out_exc=1, out_cause=10 (RI).
REQ-023 Fields not used by the instruction are 0 (never high-Z); rs=instr[25:21], rt=instr[20:16], shamt=instr[10:6], imm=instr[15:0], addr=instr[25:0] where used.
REQ-024 out_rd: instr[20:16] for I-type writers (addi addiu andi ori xori lw lb lh lbu lhu slti sltiu lui mfc0), 31 for jal, instr[15:11] for R-type writers, jalr, clz, mul, mfhi, mflo, mtc0; out_wr=1 for all of these except mtc0.
REQ-025 Pointers wrap modulo DEPTH; full: in_ready=0, input held upstream; empty: out_valid=0, outputs hold last value or 0 after reset.
REQ-026 Pop at full does not raise in_ready in the same cycle; in_ready depends only on registered count.
REQ-027 flush: next cycle count=0, out_valid=0, same-cycle push and pop both ignored; flush has priority.

Reset
REQ-028 rst_n low: pointers and count 0, out_valid 0, in_ready 1, all bundle outputs 0, immediately and independent of clk.
REQ-029 Reset asserted mid-transfer drops all entries; first push after release is the new head.

Configuration
REQ-030 Macro DECODE_TRAP_EN defined: break, syscall, teq decode to ids 45-47 with out_exc=1 and out_cause 9, 8, 13 respectively (teq raises out_exc at decode; execute qualifies with rs==rt).
REQ-031 DECODE_TRAP_EN undefined: break, syscall, teq are treated as unmatched (out_op=0, out_exc=1, out_cause=10).

Verification
REQ-032 Push 0x00221821 (addu $3,$1,$2) pc 0x400 -> next cycle out_valid=1, out_op=2, rs=1, rt=2, rd=3, out_wr=1, imm=0, out_exc=0.
REQ-033 DEPTH=4, push 5 back-to-back, out_ready=0 -> 4 accepted, count=4, in_ready=0; one pop -> in_ready=1 next cycle, 5th accepted, FIFO order preserved on pc.
REQ-034 3 entries, flush with in_valid=1 -> next cycle count=0, out_valid=0, flushed input never emerges.
REQ-035 Push 0x0000000C -> with DECODE_TRAP_EN out_op=46, out_exc=1, out_cause=8; without it out_op=0, out_cause=10.
REQ-036 Push 0x0C000010 (jal) -> out_op=31, rd=31, out_wr=1, addr=0x10; push 0xFC000000 -> out_op=0, out_exc=1, out_cause=10.
REQ-037 rst_n pulsed low with 2 entries between clock edges -> outputs 0 and count 0 immediately, in_ready=1.
